// File: rtl/kronos_step_pkg.sv
// rtl/kronos_step_pkg.sv - shared types for the Kronos step controller (KRONOS_STEP_BP_EN adds S_BPHALT)
package kronos_step_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_DIV   = 2'b01,
        MODE_STEP  = 2'b10,
        MODE_BURST = 2'b11
    } step_mode_e;

`ifdef KRONOS_STEP_BP_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_BURST  = 2'd2,
        S_BPHALT = 2'd3
    } step_state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2
    } step_state_e;
`endif

    localparam int BURST_MIN = 1;

    // Stepped modes only issue pulses in response to a step request.
    function automatic logic is_stepped(input step_mode_e m);
        return (m == MODE_STEP) || (m == MODE_BURST);
    endfunction

endpackage

// File: rtl/kronos_step_div.sv
// rtl/kronos_step_div.sv - free-running rate divider producing one tick every DIVIDER enabled cycles
module kronos_step_div #(
    parameter int          DIV_WIDTH = 32,
    parameter int unsigned DIVIDER   = 5000000
) (
    input  logic clk,
    input  logic rstz,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(DIVIDER - 1);

    logic [DIV_WIDTH-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/kronos_step_ctrl.sv
// rtl/kronos_step_ctrl.sv - run/divided/step/burst core clock-enable controller; KRONOS_STEP_BP_EN adds an address breakpoint
module kronos_step_ctrl
    import kronos_step_pkg::*;
#(
    parameter int          DIV_WIDTH   = 32,
    parameter int unsigned DIVIDER     = 5000000,
    parameter int          BURST_WIDTH = 8,
    parameter int          CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rstz,
    input  logic [1:0]             mode,
    input  logic                   step_req,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   resume,
    input  logic [31:0]            instr_addr,
    input  logic [31:0]            bp_addr,
    input  logic                   bp_valid,
    output logic                   core_en,
    output logic                   halted,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   retired
);

    step_mode_e             mode_e;
    step_state_e            state;
    step_state_e            state_nx;
    logic [BURST_WIDTH-1:0] bcnt;
    logic [BURST_WIDTH-1:0] bcnt_nx;
    logic [BURST_WIDTH-1:0] burst_load;
    logic                   en_nx;
    logic                   step_hist;
    logic                   step_edge;
    logic                   div_en;
    logic                   div_clr;
    logic                   div_tick;
    logic                   bp_hit;

    assign mode_e     = step_mode_e'(mode);
    assign step_edge  = step_req && !step_hist;
    assign burst_load = (burst_len < BURST_WIDTH'(BURST_MIN)) ? BURST_WIDTH'(BURST_MIN) : burst_len;

    assign div_en  = (state == S_RUN) && (mode_e == MODE_DIV);
    assign div_clr = !div_en;

    kronos_step_div #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIVIDER   (DIVIDER)
    ) u_div (
        .clk  (clk),
        .rstz (rstz),
        .clr  (div_clr),
        .en   (div_en),
        .tick (div_tick)
    );

`ifdef KRONOS_STEP_BP_EN
    logic resume_hist;
    logic resume_edge;
    logic addr_match;
    logic bp_mask;

    assign resume_edge = resume && !resume_hist;
    assign addr_match  = bp_valid && (instr_addr == bp_addr);
    // After a resume the compare stays masked until the core has moved off the
    // breakpoint address, so the halted instruction can execute.
    assign bp_hit      = addr_match && !bp_mask && ((state == S_RUN) || (state == S_BURST));

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            resume_hist <= 1'b0;
            bp_mask     <= 1'b0;
        end else begin
            resume_hist <= resume;
            if ((state == S_BPHALT) && resume_edge) begin
                bp_mask <= 1'b1;
            end else begin
                bp_mask <= bp_mask && addr_match;
            end
        end
    end
`else
    logic unused_bp;

    assign bp_hit    = 1'b0;
    assign unused_bp = ^{resume, instr_addr, bp_addr, bp_valid};
`endif

    always_comb begin
        state_nx = state;
        bcnt_nx  = bcnt;
        en_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!is_stepped(mode_e)) begin
                    state_nx = S_RUN;
                end else if (step_edge) begin
                    state_nx = S_BURST;
                    bcnt_nx  = (mode_e == MODE_STEP) ? BURST_WIDTH'(BURST_MIN) : burst_load;
                end
            end
            S_RUN: begin
                if (bp_hit) begin
`ifdef KRONOS_STEP_BP_EN
                    state_nx = S_BPHALT;
`endif
                end else if (is_stepped(mode_e)) begin
                    state_nx = S_IDLE;
                end else begin
                    en_nx = (mode_e == MODE_RUN) || div_tick;
                end
            end
            S_BURST: begin
                if (bp_hit) begin
`ifdef KRONOS_STEP_BP_EN
                    state_nx = S_BPHALT;
`endif
                    bcnt_nx  = '0;
                end else begin
                    en_nx   = 1'b1;
                    bcnt_nx = bcnt - BURST_WIDTH'(1);
                    if (bcnt <= BURST_WIDTH'(1)) begin
                        state_nx = S_IDLE;
                    end
                end
            end
`ifdef KRONOS_STEP_BP_EN
            S_BPHALT: begin
                if (resume_edge) begin
                    state_nx = S_IDLE;
                end
            end
`endif
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state     <= S_IDLE;
            bcnt      <= '0;
            core_en   <= 1'b0;
            step_hist <= 1'b0;
            retired   <= '0;
        end else begin
            state     <= state_nx;
            bcnt      <= bcnt_nx;
            core_en   <= en_nx;
            step_hist <= step_req;
            retired   <= retired + CNT_WIDTH'(core_en);
        end
    end

    // In DIV mode the core is effectively stopped between divider pulses.
    always_comb begin
        halted = (state == S_IDLE) ||
                 ((state == S_RUN) && (mode_e == MODE_DIV) && !core_en);
`ifdef KRONOS_STEP_BP_EN
        halted = halted || (state == S_BPHALT);
`endif
    end

    assign busy = (state == S_BURST);

endmodule

// File: tb/tb_kronos_step_ctrl.sv
// tb/tb_kronos_step_ctrl.sv - self-checking bench for kronos_step_ctrl (breakpoint checks when KRONOS_STEP_BP_EN is defined)
module tb_kronos_step_ctrl;
    import kronos_step_pkg::*;

    localparam int NRAND = 1500;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        step_req = 1'b0;
    logic [7:0]  burst_len = 8'd0;
    logic        resume = 1'b0;
    logic [31:0] instr_addr = 32'd0;
    logic [31:0] bp_addr = 32'd0;
    logic        bp_valid = 1'b0;
    logic        core_en;
    logic        halted;
    logic        busy;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kronos_step_ctrl #(
        .DIV_WIDTH   (32),
        .DIVIDER     (4),
        .BURST_WIDTH (8),
        .CNT_WIDTH   (32)
    ) dut (
        .clk        (clk),
        .rstz       (rstz),
        .mode       (mode),
        .step_req   (step_req),
        .burst_len  (burst_len),
        .resume     (resume),
        .instr_addr (instr_addr),
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
        .core_en    (core_en),
        .halted     (halted),
        .busy       (busy),
        .retired    (retired)
    );

    typedef struct {
        logic [1:0] m;
        logic [7:0] len;
        int         edges;
        int         gap;
        int         exp_pulses;
        int         exp_segs;
    } vec_t;

    vec_t vecs[6];
    bit   exp_en[0:NRAND+20];
    bit   exp_busy[0:NRAND+20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        rstz = 1'b0;
        mode = m;
        step_req = 1'b0;
        resume = 1'b0;
        burst_len = 8'd0;
        instr_addr = 32'd0;
        bp_addr = 32'd0;
        bp_valid = 1'b0;
        repeat (3) cyc();
        rstz = 1'b1;
    endtask

    initial begin
        int pulses;
        int busyc;
        int first;
        int segs;
        logic prev;
        int bound;
        int free_at;
        int n;
        int retired_exp;
        logic prev_req;

        // Reset and free-run entry
        do_reset(MODE_RUN);
        rstz = 1'b0;
        cyc();
        chk("reset_core_en", core_en, 0);
        chk("reset_halted", halted, 1);
        chk("reset_busy", busy, 0);
        chk("reset_retired", retired, 0);
        rstz = 1'b1;
        cyc();
        chk("run_cycle1_no_pulse", core_en, 0);
        for (int k = 2; k <= 11; k++) begin
            cyc();
            chk("run_pulse_every_cycle", core_en, 1);
            chk("run_not_halted", halted, 0);
        end
        chk("run_retired", retired, 9);

        // Divided run: DIVIDER=4, pulses at 5, 9, 13 after entry
        do_reset(MODE_STEP);
        mode = MODE_DIV;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            chk("div_pulse", core_en, (k == 5 || k == 9 || k == 13) ? 1 : 0);
            chk("div_halted", halted, (k == 5 || k == 9 || k == 13) ? 0 : 1);
        end
        chk("div_retired", retired, 3);
        mode = MODE_STEP;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (core_en) pulses++;
        end
        chk("div_exit_no_pulses", pulses, 0);
        chk("div_exit_halted", halted, 1);

        // Table-driven STEP/BURST sequences
        vecs[0] = '{MODE_STEP,  8'd0,   3, 10, 3,   3};
        vecs[1] = '{MODE_BURST, 8'd5,   1, 10, 5,   1};
        vecs[2] = '{MODE_BURST, 8'd0,   1, 10, 1,   1};
        vecs[3] = '{MODE_BURST, 8'd1,   1, 10, 1,   1};
        vecs[4] = '{MODE_BURST, 8'd255, 1, 10, 255, 1};
        vecs[5] = '{MODE_STEP,  8'd200, 2, 10, 2,   2};
        foreach (vecs[i]) begin
            do_reset(vecs[i].m);
            burst_len = vecs[i].len;
            pulses = 0; busyc = 0; first = -1; segs = 0; prev = 1'b0;
            for (int k = 0; k < vecs[i].edges * vecs[i].gap + vecs[i].exp_pulses + 5; k++) begin
                step_req = ((k % vecs[i].gap) == 0) && ((k / vecs[i].gap) < vecs[i].edges);
                cyc();
                if (core_en) begin
                    pulses++;
                    if (first < 0) first = k + 1;
                    if (!prev) segs++;
                end
                prev = core_en;
                if (busy) busyc++;
            end
            step_req = 1'b0;
            chk($sformatf("vec%0d_latency", i), first, 2);
            chk($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
            chk($sformatf("vec%0d_busy_cycles", i), busyc, vecs[i].exp_pulses);
            chk($sformatf("vec%0d_segments", i), segs, vecs[i].exp_segs);
            chk($sformatf("vec%0d_retired", i), retired, vecs[i].exp_pulses);
        end

        // Second edge during a burst is dropped
        do_reset(MODE_BURST);
        burst_len = 8'd5;
        pulses = 0; segs = 0; prev = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step_req = (k == 0) || (k == 3);
            cyc();
            if (core_en) begin
                pulses++;
                if (!prev) segs++;
            end
            prev = core_en;
        end
        step_req = 1'b0;
        chk("drop_pulses", pulses, 5);
        chk("drop_segments", segs, 1);
        chk("drop_retired", retired, 5);

        // Asynchronous reset in the middle of a long burst
        do_reset(MODE_BURST);
        burst_len = 8'd200;
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        pulses = 0;
        bound = 0;
        while (pulses < 50 && bound < 300) begin
            cyc();
            if (core_en) pulses++;
            bound++;
        end
        chk("async_reach_pulse50", pulses, 50);
        #1 rstz = 1'b0;
        #1;
        chk("async_core_en", core_en, 0);
        chk("async_busy", busy, 0);
        chk("async_halted", halted, 1);
        chk("async_retired", retired, 0);
        cyc();
        cyc();
        rstz = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (core_en) pulses++;
        end
        chk("async_no_pulse_after_release", pulses, 0);
        chk("async_idle_halted", halted, 1);

        // Randomised STEP/BURST traffic against a schedule model
        do_reset(MODE_STEP);
        foreach (exp_en[i]) begin
            exp_en[i] = 1'b0;
            exp_busy[i] = 1'b0;
        end
        free_at = 0;
        retired_exp = 0;
        prev_req = 1'b0;
        for (int k = 0; k < NRAND; k++) begin
            mode = 2'($urandom_range(2, 3));
            burst_len = 8'($urandom_range(0, 6));
            step_req = ($urandom_range(0, 5) == 0);
            if (step_req && !prev_req && k >= free_at) begin
                n = (mode == MODE_STEP) ? 1 : ((burst_len == 0) ? 1 : int'(burst_len));
                for (int j = 1; j <= n; j++) begin
                    exp_busy[k + j] = 1'b1;
                    exp_en[k + j + 1] = 1'b1;
                end
                free_at = k + n + 1;
            end
            prev_req = step_req;
            cyc();
            chk("rand_core_en", core_en, exp_en[k + 1]);
            chk("rand_busy", busy, exp_busy[k + 1]);
            chk("rand_halted", halted, !exp_busy[k + 1]);
            chk("rand_retired", retired, retired_exp);
            retired_exp += int'(exp_en[k + 1]);
        end
        step_req = 1'b0;

`ifdef KRONOS_STEP_BP_EN
        // Breakpoint hit, hold, resume past the address, re-arm
        do_reset(MODE_RUN);
        bp_addr = 32'h40;
        bp_valid = 1'b1;
        instr_addr = 32'h10;
        for (int k = 1; k <= 6; k++) cyc();
        chk("bp_running", core_en, 1);
        instr_addr = 32'h40;
        cyc();
        chk("bp_hit_suppress", core_en, 0);
        chk("bp_hit_halted", halted, 1);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (core_en) pulses++;
        end
        chk("bp_hold_no_pulses", pulses, 0);
        chk("bp_hold_halted", halted, 1);
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        cyc();
        chk("bp_resume_gap", core_en, 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("bp_no_retrigger", core_en, 1);
            chk("bp_resumed_halted", halted, 0);
        end
        instr_addr = 32'h44;
        cyc();
        instr_addr = 32'h40;
        cyc();
        chk("bp_rearm_hit", core_en, 0);
        chk("bp_rearm_halted", halted, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
